mos6502s_push_sequencer: RTL and testbench

- Writer-side counterpart to the byte-wise address/operand capture path.
- Serialises a 16-bit value (PC), plus an optional status byte, onto the 8-bit data bus as stack write cycles at page 0x01.
- Used for JSR/BRK/IRQ/NMI pushes.
- Owns the stack-pointer decrement during the sequence and hands the final SP back to the register file.

---
 rtl/mos6502s_pkg.sv | 19 +
 rtl/mos6502s_push_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mos6502s_push_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mos6502s_pkg.sv
// Shared definitions for the mos6502s core: push sequencer states, stack page
// and the interrupt/reset vector addresses that feed the PC sources.
package mos6502s_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_P,
        DONE
    } push_state_t;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/mos6502s_push_sequencer.sv
// Stack push sequencer: writes PC high, PC low and optionally P to page STACK_PAGE.
// Optional macro MOS6502S_PUSH_RDY_EN enables rdy-driven write stalls.
module mos6502s_push_sequencer
    import mos6502s_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        push_status,
    input  logic [15:0] value_in,
    input  logic [7:0]  status_in,
    input  logic [7:0]  sp_in,
    input  logic        rdy,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sp_out,
    output logic        sp_we
);

    push_state_t r_state, w_state_nxt;
    logic [15:0] r_value, w_value_nxt;
    logic [7:0]  r_status, w_status_nxt;
    logic        r_push_p, w_push_p_nxt;
    logic [7:0]  r_sp, w_sp_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_we, w_we_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [7:0]  r_sp_out, w_sp_out_nxt;
    logic        r_sp_we, w_sp_we_nxt;
    logic [7:0]  w_sp_dec;
    logic        w_advance;

`ifdef MOS6502S_PUSH_RDY_EN
    assign w_advance = rdy;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = rdy;
    assign w_advance    = 1'b1;
`endif

    assign w_sp_dec = r_sp - 8'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_value_nxt  = r_value;
        w_status_nxt = r_status;
        w_push_p_nxt = r_push_p;
        w_sp_nxt     = r_sp;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_we_nxt     = r_we;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_sp_out_nxt = r_sp_out;
        w_sp_we_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_we_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_value_nxt  = value_in;
                    w_status_nxt = status_in;
                    w_push_p_nxt = push_status;
                    w_sp_nxt     = sp_in;
                    w_addr_nxt   = {STACK_PAGE, sp_in};
                    w_data_nxt   = value_in[15:8];
                    w_we_nxt     = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = PUSH_HI;
                end
            end
            PUSH_HI: begin
                if (w_advance) begin
                    w_sp_nxt    = w_sp_dec;
                    w_addr_nxt  = {STACK_PAGE, w_sp_dec};
                    w_data_nxt  = r_value[7:0];
                    w_state_nxt = PUSH_LO;
                end
            end
            PUSH_LO: begin
                if (w_advance) begin
                    w_sp_nxt = w_sp_dec;
                    if (r_push_p) begin
                        w_addr_nxt  = {STACK_PAGE, w_sp_dec};
                        w_data_nxt  = r_status;
                        w_state_nxt = PUSH_P;
                    end else begin
                        w_we_nxt     = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_sp_we_nxt  = 1'b1;
                        w_sp_out_nxt = w_sp_dec;
                        w_state_nxt  = DONE;
                    end
                end
            end
            PUSH_P: begin
                if (w_advance) begin
                    w_sp_nxt     = w_sp_dec;
                    w_we_nxt     = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_sp_we_nxt  = 1'b1;
                    w_sp_out_nxt = w_sp_dec;
                    w_state_nxt  = DONE;
                end
            end
            DONE: begin
                // addr/data keep the last written values while idle
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_we_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_value  <= 16'h0000;
            r_status <= 8'h00;
            r_push_p <= 1'b0;
            r_sp     <= 8'h00;
            r_addr   <= 16'h0000;
            r_data   <= 8'h00;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sp_out <= 8'h00;
            r_sp_we  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_value  <= w_value_nxt;
            r_status <= w_status_nxt;
            r_push_p <= w_push_p_nxt;
            r_sp     <= w_sp_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_we     <= w_we_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_sp_out <= w_sp_out_nxt;
            r_sp_we  <= w_sp_we_nxt;
        end
    end

    assign addr     = r_addr;
    assign data_out = r_data;
    assign we       = r_we;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sp_out   = r_sp_out;
    assign sp_we    = r_sp_we;

endmodule

// File: tb/tb_mos6502s_push_sequencer.sv
// Bench for mos6502s_push_sequencer: cycle-level reference model built from the
// list of bytes to push, with directed and randomized sequences.
module tb_mos6502s_push_sequencer;

`ifdef MOS6502S_PUSH_RDY_EN
    localparam bit RdyEn = 1'b1;
`else
    localparam bit RdyEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        push_status;
    logic [15:0] value_in;
    logic [7:0]  status_in;
    logic [7:0]  sp_in;
    logic        rdy;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        we;
    logic        busy;
    logic        done;
    logic [7:0]  sp_out;
    logic        sp_we;

    int tests = 0;
    int fails = 0;

    mos6502s_push_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .push_status(push_status),
        .value_in   (value_in),
        .status_in  (status_in),
        .sp_in      (sp_in),
        .rdy        (rdy),
        .addr       (addr),
        .data_out   (data_out),
        .we         (we),
        .busy       (busy),
        .done       (done),
        .sp_out     (sp_out),
        .sp_we      (sp_we)
    );

    always #5 clk = ~clk;

    // rdy_mode: 0 always ready, 1 random, 2 not ready on the first two write cycles.
    // hostile:  0 quiet, 1 start held with value 16'hFFFF, 2 random inputs.
    task automatic run_seq(input logic [15:0] v, input logic [7:0] st, input logic [7:0] sp,
                           input logic p, input int rdy_mode, input int hostile,
                           input string name);
        logic [7:0]  bytes [3];
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_we, e_busy, e_done;
        int          n, idx;
        bit          finished;
        bytes[0] = v[15:8];
        bytes[1] = v[7:0];
        bytes[2] = st;
        n        = p ? 3 : 2;
        idx      = 0;
        finished = 1'b0;
        @(negedge clk);
        start = 1'b1; value_in = v; status_in = st; sp_in = sp; push_status = p; rdy = 1'b1;
        for (int cyc = 1; cyc < 64; cyc++) begin
            @(negedge clk);
            if (idx < n) begin
                e_we = 1'b1; e_busy = 1'b1; e_done = 1'b0;
                e_addr = {8'h01, sp - 8'(idx)};
                e_data = bytes[idx];
            end else begin
                e_we = 1'b0; e_busy = (idx == n); e_done = (idx == n);
                e_addr = {8'h01, sp - 8'(n - 1)};
                e_data = bytes[n-1];
            end
            tests++;
            if ({we, busy, done, sp_we, addr, data_out} !==
                {e_we, e_busy, e_done, e_done, e_addr, e_data}) begin
                fails++;
                $display("FAIL %s cyc %0d: got we=%b busy=%b done=%b sp_we=%b addr=%h data=%h, want we=%b busy=%b done=%b sp_we=%b addr=%h data=%h",
                         name, cyc, we, busy, done, sp_we, addr, data_out,
                         e_we, e_busy, e_done, e_done, e_addr, e_data);
            end
            if (e_done) begin
                tests++;
                if (sp_out !== sp - 8'(n)) begin
                    fails++;
                    $display("FAIL %s sp_out: got %h want %h", name, sp_out, sp - 8'(n));
                end
            end
            if (idx == n + 1) begin
                finished = 1'b1;
                break;
            end
            case (hostile)
                1: begin start = 1'b1; value_in = 16'hFFFF; status_in = 8'hFF;
                         sp_in = 8'h00; push_status = ~p; end
                2: begin start = 1'($urandom_range(0, 1)); value_in = 16'($urandom);
                         status_in = 8'($urandom); sp_in = 8'($urandom);
                         push_status = 1'($urandom_range(0, 1)); end
                default: start = 1'b0;
            endcase
            case (rdy_mode)
                1: rdy = (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
                2: rdy = !(cyc == 1 || cyc == 2);
                default: rdy = 1'b1;
            endcase
            if (idx < n) begin
                if (!RdyEn || rdy) idx++;
            end else begin
                idx++;
            end
        end
        start = 1'b0;
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: sequence did not return to idle within budget", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; push_status = 1'b0; value_in = 16'h0; status_in = 8'h0;
        sp_in = 8'h0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({addr, data_out, we, busy, done, sp_out, sp_we} !== 43'h0) begin
            fails++;
            $display("FAIL reset: got addr=%h data=%h we=%b busy=%b done=%b sp_out=%h sp_we=%b, want all 0",
                     addr, data_out, we, busy, done, sp_out, sp_we);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_seq(16'h1234, 8'h00, 8'hFD, 1'b0, 0, 0, "pc_only");
        run_seq(16'hABCD, 8'h30, 8'hFF, 1'b1, 0, 0, "pc_status");
        run_seq(16'h5566, 8'h24, 8'h01, 1'b1, 0, 0, "sp_wrap");
        run_seq(16'h9A00, 8'h00, 8'h00, 1'b0, 0, 0, "sp_zero");
    endtask

    task automatic test_back_to_back();
        run_seq(16'h1234, 8'h00, 8'hFD, 1'b0, 0, 1, "busy_start_pc");
        run_seq(16'h4321, 8'hC3, 8'h80, 1'b1, 0, 1, "busy_start_status");
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; value_in = 16'h7788; status_in = 8'h11; sp_in = 8'hF0;
        push_status = 1'b1; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({addr, data_out, we, busy, done, sp_out, sp_we} !== 43'h0) begin
            fails++;
            $display("FAIL abort: got addr=%h data=%h we=%b busy=%b done=%b sp_out=%h sp_we=%b, want all 0",
                     addr, data_out, we, busy, done, sp_out, sp_we);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({we, busy, done, sp_we} !== 4'b0) begin
                fails++;
                $display("FAIL abort_quiet cyc %0d: got we=%b busy=%b done=%b sp_we=%b, want 0",
                         i, we, busy, done, sp_we);
            end
        end
        run_seq(16'h2468, 8'h00, 8'h10, 1'b0, 0, 0, "after_abort");
    endtask

    task automatic test_rdy_stall();
        run_seq(16'h1234, 8'h00, 8'hFD, 1'b0, 2, 0, "rdy_stall");
        run_seq(16'hBEEF, 8'h5A, 8'h02, 1'b1, 2, 0, "rdy_stall_status");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_seq(16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    1, 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_rdy_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
